s_mem_arbiter: RTL and testbench

Round-robin arbiter and access sequencer for the shared 256×8 single-port S-array RAM used by the RC4 datapath. Three requesters share the RAM through a request/grant handshake: 0 is array init, 1 is key schedule, and 2 is keystream generation. The arbiter muxes the owning requester's address, write data and write enable onto the RAM port, and flags returned read data back to that owner. It sits between the phase FSMs and the RAM instance in the task top level.

---
 rtl/s_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_s_mem_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/s_mem_arbiter.sv
// rtl/s_mem_arbiter.sv - round-robin owner arbiter and access mux for the shared S-array RAM
// Optional ownership timeout is built when S_ARB_TIMEOUT_EN is defined.
module s_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [2:0]        wren,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wrdata0,
  input  logic [DATA_W-1:0] wrdata1,
  input  logic [DATA_W-1:0] wrdata2,
  output logic [2:0]        grant,
  output logic [DATA_W-1:0] rddata,
  output logic [2:0]        rdvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [2:0]        grant_q, grant_d;
  logic [2:0]        rdvalid_q, rdvalid_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] wrdata_hold_q, wrdata_hold_d;

  logic              own_req, own_wren, access, preempt, arbitrate;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wrdata;
  logic [1:0]        p0, p1, p2, win_idx;
  logic              win_found;

  // Owner-side view of the requester inputs; non-owners never reach the RAM port.
  always_comb begin
    own_req    = 1'b0;
    own_wren   = 1'b0;
    own_addr   = addr0;
    own_wrdata = wrdata0;
    case (owner_q)
      2'd0: begin
        own_req = req[0]; own_wren = wren[0]; own_addr = addr0; own_wrdata = wrdata0;
      end
      2'd1: begin
        own_req = req[1]; own_wren = wren[1]; own_addr = addr1; own_wrdata = wrdata1;
      end
      2'd2: begin
        own_req = req[2]; own_wren = wren[2]; own_addr = addr2; own_wrdata = wrdata2;
      end
      default: begin
        own_req = 1'b0; own_wren = 1'b0; own_addr = addr0; own_wrdata = wrdata0;
      end
    endcase
  end

  assign access = (state_q == OWN) && own_req;

  // Scan order starts one past the last winner, wrapping mod 3.
  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (last_q)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
  end

  function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
    case (i)
      2'd0:    req_at = r[0];
      2'd1:    req_at = r[1];
      2'd2:    req_at = r[2];
      default: req_at = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  always_comb begin
    win_found = 1'b1;
    win_idx   = p0;
    if (req_at(req, p0)) begin
      win_idx = p0;
    end else if (req_at(req, p1)) begin
      win_idx = p1;
    end else if (req_at(req, p2)) begin
      win_idx = p2;
    end else begin
      win_found = 1'b0;
    end
  end

`ifdef S_ARB_TIMEOUT_EN
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // Preempt only when someone else is actually waiting; otherwise the count saturates.
  assign preempt = (state_q == OWN) && (hold_cnt_q == CNT_TOP) && |(req & ~grant_q);

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (arbitrate) begin
      hold_cnt_d = '0;
    end else if ((state_q == OWN) && (hold_cnt_q != CNT_TOP)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_hold_max;
  assign unused_hold_max = (HOLD_MAX > 0);
  assign preempt = 1'b0;
`endif

  assign arbitrate = (state_q == IDLE) || !own_req || preempt;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    grant_d       = grant_q;
    rdvalid_d     = 3'b000;
    addr_hold_d   = addr_hold_q;
    wrdata_hold_d = wrdata_hold_q;

    if (arbitrate) begin
      if (win_found) begin
        state_d = OWN;
        owner_d = win_idx;
        last_d  = win_idx;
        grant_d = onehot(win_idx);
      end else begin
        state_d = IDLE;
        owner_d = 2'd0;
        grant_d = 3'b000;
      end
    end

    if (access) begin
      addr_hold_d   = own_addr;
      wrdata_hold_d = own_wrdata;
      if (!own_wren) begin
        rdvalid_d = grant_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 2'd0;
      last_q        <= 2'd2;
      grant_q       <= 3'b000;
      rdvalid_q     <= 3'b000;
      addr_hold_q   <= '0;
      wrdata_hold_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      rdvalid_q     <= rdvalid_d;
      addr_hold_q   <= addr_hold_d;
      wrdata_hold_q <= wrdata_hold_d;
    end
  end

  // Port is live only in access cycles; otherwise it parks on the last owner access.
  assign mem_addr   = access ? own_addr : addr_hold_q;
  assign mem_wrdata = access ? own_wrdata : wrdata_hold_q;
  assign mem_wren   = access && own_wren;
  assign grant      = grant_q;
  assign rdvalid    = rdvalid_q;
  assign rddata     = mem_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb/tb_s_mem_arbiter.sv - directed vector bench for s_mem_arbiter with a registered-address RAM model
module tb_s_mem_arbiter;

  logic       clk, rst;
  logic [2:0] req, wren;
  logic [7:0] addr0, addr1, addr2, wrdata0, wrdata1, wrdata2;
  logic [2:0] grant, rdvalid;
  logic [7:0] rddata, mem_addr, mem_wrdata, mem_q;
  logic       mem_wren;

  logic [7:0] ram [256];
  logic [7:0] ram_addr_q;

  int total = 0;
  int bad   = 0;

  s_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req), .wren(wren),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wrdata0(wrdata0), .wrdata1(wrdata1), .wrdata2(wrdata2),
    .grant(grant), .rddata(rddata), .rdvalid(rdvalid),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wrdata;
    ram_addr_q <= mem_addr;
  end
  assign mem_q = ram[ram_addr_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] wren;
    logic [7:0] a0, a1, a2, d1, d2;
    logic       e_wren;
    logic [7:0] e_addr, e_wdata;
    logic [2:0] e_grant, e_rdv;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vt [14];
  int   n;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram_addr_q = 8'h00;
    rst = 1'b1; req = 3'b000; wren = 3'b000;
    addr0 = 0; addr1 = 0; addr2 = 0; wrdata0 = 0; wrdata1 = 0; wrdata2 = 0;

    //          req     wren    a0     a1     a2     d1     d2    ewr  eaddr  ewdat  egrant  erdv    erdata
    vt[0]  = '{3'b111, 3'b000, 8'h01, 8'h11, 8'h21, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 3'b001, 3'b000, 8'h00};
    vt[1]  = '{3'b111, 3'b000, 8'h02, 8'h11, 8'h21, 8'h00, 8'h00, 1'b0, 8'h02, 8'h00, 3'b001, 3'b001, 8'h58};
    vt[2]  = '{3'b110, 3'b100, 8'h03, 8'h12, 8'h33, 8'h00, 8'hEE, 1'b0, 8'h02, 8'h00, 3'b010, 3'b000, 8'h00};
    vt[3]  = '{3'b110, 3'b110, 8'h03, 8'h10, 8'h33, 8'hA5, 8'hEE, 1'b1, 8'h10, 8'hA5, 3'b010, 3'b000, 8'h00};
    vt[4]  = '{3'b110, 3'b100, 8'h03, 8'h10, 8'h33, 8'h77, 8'hEE, 1'b0, 8'h10, 8'h00, 3'b010, 3'b010, 8'hA5};
    vt[5]  = '{3'b100, 3'b000, 8'h03, 8'h10, 8'h40, 8'h00, 8'h00, 1'b0, 8'h10, 8'h00, 3'b100, 3'b000, 8'h00};
    vt[6]  = '{3'b100, 3'b000, 8'h03, 8'h10, 8'h40, 8'h00, 8'h00, 1'b0, 8'h40, 8'h00, 3'b100, 3'b100, 8'h1A};
    vt[7]  = '{3'b000, 3'b000, 8'h03, 8'h10, 8'h40, 8'h00, 8'h00, 1'b0, 8'h40, 8'h00, 3'b000, 3'b000, 8'h00};
    vt[8]  = '{3'b011, 3'b000, 8'h05, 8'h10, 8'h33, 8'h00, 8'h00, 1'b0, 8'h40, 8'h00, 3'b001, 3'b000, 8'h00};
    vt[9]  = '{3'b111, 3'b100, 8'h05, 8'h10, 8'h33, 8'h00, 8'hEE, 1'b0, 8'h05, 8'h00, 3'b001, 3'b001, 8'h5F};
    vt[10] = '{3'b110, 3'b100, 8'h05, 8'h10, 8'h33, 8'h00, 8'hEE, 1'b0, 8'h05, 8'h00, 3'b010, 3'b000, 8'h00};
    vt[11] = '{3'b110, 3'b010, 8'h05, 8'h20, 8'h33, 8'h3C, 8'h00, 1'b1, 8'h20, 8'h3C, 3'b010, 3'b000, 8'h00};
    vt[12] = '{3'b100, 3'b000, 8'h05, 8'h20, 8'h33, 8'h00, 8'h00, 1'b0, 8'h20, 8'h00, 3'b100, 3'b000, 8'h00};
    vt[13] = '{3'b000, 3'b000, 8'h05, 8'h20, 8'h33, 8'h00, 8'h00, 1'b0, 8'h20, 8'h00, 3'b000, 3'b000, 8'h00};

    #12;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_rdvalid", 32'(rdvalid), 32'h0);
    chk("rst_mem_wren", 32'(mem_wren), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wrdata", 32'(mem_wrdata), 32'h0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      req = vt[i].req; wren = vt[i].wren;
      addr0 = vt[i].a0; addr1 = vt[i].a1; addr2 = vt[i].a2;
      wrdata0 = 8'hC0; wrdata1 = vt[i].d1; wrdata2 = vt[i].d2;
      #1;
      chk($sformatf("v%0d_mem_wren", i), 32'(mem_wren), 32'(vt[i].e_wren));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
      if (vt[i].e_wren) chk($sformatf("v%0d_mem_wrdata", i), 32'(mem_wrdata), 32'(vt[i].e_wdata));
      @(posedge clk); #1;
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vt[i].e_grant));
      chk($sformatf("v%0d_rdvalid", i), 32'(rdvalid), 32'(vt[i].e_rdv));
      if (vt[i].e_rdv != 3'b000) chk($sformatf("v%0d_rddata", i), 32'(rddata), 32'(vt[i].e_rdata));
    end
    chk("ram_33_untouched", 32'(ram[8'h33]), 32'h69);
    chk("ram_10_written", 32'(ram[8'h10]), 32'hA5);
    chk("ram_20_written", 32'(ram[8'h20]), 32'h3C);

    // Asynchronous reset in the middle of an owner 0 burst.
    @(negedge clk); req = 3'b111; wren = 3'b000; addr0 = 8'h60;
    @(posedge clk); #1; chk("mr_grant0", 32'(grant), 32'b001);
    @(posedge clk); #1; chk("mr_rdvalid0", 32'(rdvalid), 32'b001);
    wren = 3'b001; addr0 = 8'h61;
    #1; chk("mr_mem_wren_on", 32'(mem_wren), 32'h1);
    #1; rst = 1'b1;
    #1;
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_rdvalid", 32'(rdvalid), 32'h0);
    chk("mr_mem_wren", 32'(mem_wren), 32'h0);
    chk("mr_mem_addr", 32'(mem_addr), 32'h0);
    req = 3'b110; wren = 3'b000;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1; chk("mr_first_grant", 32'(grant), 32'b010);

    // Timeout behaviour: fresh owner 0 with requester 2 waiting.
    @(negedge clk) req = 3'b000;
    @(posedge clk); #1; chk("to_idle", 32'(grant), 32'h0);
    @(negedge clk) req = 3'b001;
    @(posedge clk); #1; chk("to_own0", 32'(grant), 32'b001);
    @(negedge clk) req = 3'b101;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (grant != 3'b001) break;
    end
`ifdef S_ARB_TIMEOUT_EN
    chk("to_preempt_grant", 32'(grant), 32'b100);
    chk("to_preempt_within", 32'(n <= 4), 32'h1);
    @(negedge clk) req = 3'b001;
    @(posedge clk); #1; chk("to_back0", 32'(grant), 32'b001);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1; chk($sformatf("to_sat%0d", k), 32'(grant), 32'b001);
    end
    @(negedge clk) req = 3'b101;
    @(posedge clk); #1; chk("to_sat_preempt", 32'(grant), 32'b100);
`else
    chk("nto_keep_grant", 32'(grant), 32'b001);
    chk("nto_cycles", 32'(n), 32'd20);
`endif
    @(negedge clk) req = 3'b000;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
